// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline types and constants for the MIPS core
package cpu_pkg;

    localparam int          DATA_W           = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0040_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - pipeline register with flush > keep > load > bubble priority
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic         i_keep,
    input  logic         i_load,
    input  logic [W-1:0] i_instr,
    input  logic [W-1:0] i_pc_plus4,
    output logic [W-1:0] o_instr,
    output logic [W-1:0] o_pc_plus4,
    output logic         o_valid
);

    // Squash, hold, capture or insert a bubble, in that priority.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            o_instr    <= W'(NOP_INSTR);
            o_pc_plus4 <= '0;
            o_valid    <= 1'b0;
        end else if (i_keep) begin
            o_instr    <= o_instr;
            o_pc_plus4 <= o_pc_plus4;
            o_valid    <= o_valid;
        end else if (i_load) begin
            o_instr    <= i_instr;
            o_pc_plus4 <= i_pc_plus4;
            o_valid    <= 1'b1;
        end else begin
            // A bubble keeps the stale pc_plus4; ID ignores it when valid is low.
            o_instr    <= W'(NOP_INSTR);
            o_valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, imem fetch FSM, hold buffer, IF/ID; FETCH_PERF_EN adds bubble/discard counters
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          DATA_W   = cpu_pkg::DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pc_keep,
    input  logic              i_IF_ID_keep,
    input  logic              i_IF_ID_flush,
    input  logic              i_redirect,
    input  logic [DATA_W-1:0] i_redirect_pc,
    output logic              o_imem_req,
    output logic [DATA_W-1:0] o_imem_addr,
    input  logic              i_imem_ready,
    input  logic              i_imem_rvalid,
    input  logic [DATA_W-1:0] i_imem_rdata,
    output logic [DATA_W-1:0] o_IF_ID_instr,
    output logic [DATA_W-1:0] o_IF_ID_pc_plus4,
    output logic              o_IF_ID_valid,
`ifdef FETCH_PERF_EN
    output logic [31:0]       o_bubble_cnt,
    output logic [31:0]       o_discard_cnt,
`endif
    output logic              o_fetch_busy
);

    fetch_state_t      state, state_next;
    logic              discard, discard_next;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] hold_instr;
    logic [DATA_W-1:0] hold_pc_plus4;
    logic              direct_load;
    logic              hold_capture;
    logic              hold_load;
    logic              if_load;
    logic [DATA_W-1:0] load_instr;
    logic [DATA_W-1:0] load_pc_plus4;

    assign pc_plus4 = pc + DATA_W'(4);

    // Next-state, discard tracking and per-cycle fetch events.
    always_comb begin
        state_next   = state;
        discard_next = discard;
        direct_load  = 1'b0;
        hold_capture = 1'b0;
        hold_load    = 1'b0;
        case (state)
            S_REQ: begin
                if (i_imem_ready) begin
                    state_next = S_WAIT;
                    // Accepted request belongs to the old PC; its reply must be dropped.
                    if (i_redirect) discard_next = 1'b1;
                end
            end
            S_WAIT: begin
                if (i_imem_rvalid) begin
                    if (discard || i_redirect) begin
                        discard_next = 1'b0;
                        state_next   = S_REQ;
                    end else if (!i_IF_ID_keep && !i_IF_ID_flush) begin
                        direct_load = 1'b1;
                        state_next  = S_REQ;
                    end else begin
                        // IF/ID cannot take the word now; park it instead of losing it.
                        hold_capture = 1'b1;
                        state_next   = S_HOLD;
                    end
                end else if (i_redirect) begin
                    discard_next = 1'b1;
                end
            end
            S_HOLD: begin
                if (i_redirect) begin
                    state_next = S_REQ;
                end else if (!i_IF_ID_keep && !i_IF_ID_flush) begin
                    hold_load  = 1'b1;
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    // State and discard flag registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_REQ;
            discard <= 1'b0;
        end else begin
            state   <= state_next;
            discard <= discard_next;
        end
    end

    assign if_load = direct_load | hold_load;

    // PC: redirect beats advance; advance only when a word actually enters IF/ID.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc <= PC_RESET;
        end else if (i_redirect) begin
            pc <= i_redirect_pc;
        end else if (if_load && !i_pc_keep) begin
            pc <= pc_plus4;
        end
    end

    // Hold buffer captures the returned word with its PC+4 while IF/ID is held.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_instr    <= '0;
            hold_pc_plus4 <= '0;
        end else if (hold_capture) begin
            hold_instr    <= i_imem_rdata;
            hold_pc_plus4 <= pc_plus4;
        end
    end

    assign load_instr    = hold_load ? hold_instr    : i_imem_rdata;
    assign load_pc_plus4 = hold_load ? hold_pc_plus4 : pc_plus4;

    if_id_reg #(.W(DATA_W)) u_if_id (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_flush    (i_IF_ID_flush),
        .i_keep     (i_IF_ID_keep),
        .i_load     (if_load),
        .i_instr    (load_instr),
        .i_pc_plus4 (load_pc_plus4),
        .o_instr    (o_IF_ID_instr),
        .o_pc_plus4 (o_IF_ID_pc_plus4),
        .o_valid    (o_IF_ID_valid)
    );

    assign o_imem_req   = (state == S_REQ);
    assign o_imem_addr  = pc;
    assign o_fetch_busy = (state == S_WAIT) || (state == S_HOLD);

`ifdef FETCH_PERF_EN
    logic bubble;
    logic drop_rsp;

    assign bubble   = !i_IF_ID_flush && !i_IF_ID_keep && !if_load;
    assign drop_rsp = (state == S_WAIT) && i_imem_rvalid && (discard || i_redirect);

    // Saturating bubble and dropped-response counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_bubble_cnt  <= '0;
            o_discard_cnt <= '0;
        end else begin
            if (bubble && (o_bubble_cnt != 32'hFFFF_FFFF))
                o_bubble_cnt <= o_bubble_cnt + 32'd1;
            if (drop_rsp && (o_discard_cnt != 32'hFFFF_FFFF))
                o_discard_cnt <= o_discard_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_keep;
    logic        if_id_keep;
    logic        if_id_flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        fetch_busy;
`ifdef FETCH_PERF_EN
    logic [31:0] bubble_cnt;
    logic [31:0] discard_cnt;
    logic [31:0] snap;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_pc_keep        (pc_keep),
        .i_IF_ID_keep     (if_id_keep),
        .i_IF_ID_flush    (if_id_flush),
        .i_redirect       (redirect),
        .i_redirect_pc    (redirect_pc),
        .o_imem_req       (imem_req),
        .o_imem_addr      (imem_addr),
        .i_imem_ready     (imem_ready),
        .i_imem_rvalid    (imem_rvalid),
        .i_imem_rdata     (imem_rdata),
        .o_IF_ID_instr    (if_id_instr),
        .o_IF_ID_pc_plus4 (if_id_pc_plus4),
        .o_IF_ID_valid    (if_id_valid),
`ifdef FETCH_PERF_EN
        .o_bubble_cnt     (bubble_cnt),
        .o_discard_cnt    (discard_cnt),
`endif
        .o_fetch_busy     (fetch_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; pc_keep = 1'b0; if_id_keep = 1'b0; if_id_flush = 1'b0;
        redirect = 1'b0; redirect_pc = '0; imem_ready = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        tick(); tick();

        // Reset state
        check("rst_req",   32'(imem_req), 32'd1);
        check("rst_addr",  imem_addr, 32'h0040_0000);
        check("rst_valid", 32'(if_id_valid), 32'd0);
        check("rst_instr", if_id_instr, 32'h0);
        check("rst_pc4",   if_id_pc_plus4, 32'h0);
        check("rst_busy",  32'(fetch_busy), 32'd0);
`ifdef FETCH_PERF_EN
        check("rst_bcnt",  bubble_cnt, 32'd0);
        check("rst_dcnt",  discard_cnt, 32'd0);
`endif

        // Basic fetch, 1-cycle memory
        rst = 1'b0; imem_ready = 1'b1;
        tick();
        check("f1_req_low", 32'(imem_req), 32'd0);
        check("f1_busy",    32'(fetch_busy), 32'd1);
        imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005;
        tick();
        imem_rvalid = 1'b0;
        check("f1_valid", 32'(if_id_valid), 32'd1);
        check("f1_instr", if_id_instr, 32'h2008_0005);
        check("f1_pc4",   if_id_pc_plus4, 32'h0040_0004);
        check("f1_next",  imem_addr, 32'h0040_0004);
        check("f1_req",   32'(imem_req), 32'd1);

        // Keep stall while the response arrives -> hold buffer
        tick();
        check("h_bubble", 32'(if_id_valid), 32'd0);
        if_id_keep = 1'b1; pc_keep = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'h8C09_0000;
        tick();
        imem_rvalid = 1'b0;
        check("h_busy",  32'(fetch_busy), 32'd1);
        check("h_req0",  32'(imem_req), 32'd0);
        check("h_valid", 32'(if_id_valid), 32'd0);
        tick();
        check("h_req1",  32'(imem_req), 32'd0);
        tick();
        check("h_req2",  32'(imem_req), 32'd0);
        check("h_addr",  imem_addr, 32'h0040_0004);
        if_id_keep = 1'b0; pc_keep = 1'b0;
        tick();
        check("h_instr", if_id_instr, 32'h8C09_0000);
        check("h_pc4",   if_id_pc_plus4, 32'h0040_0008);
        check("h_vld",   32'(if_id_valid), 32'd1);
        check("h_next",  imem_addr, 32'h0040_0008);

        // Redirect in S_WAIT, response two cycles later is dropped
`ifdef FETCH_PERF_EN
        snap = discard_cnt;
`endif
        tick();
        redirect = 1'b1; if_id_flush = 1'b1; redirect_pc = 32'h0040_0100;
        tick();
        redirect = 1'b0; if_id_flush = 1'b0;
        check("r1_flush", 32'(if_id_valid), 32'd0);
        check("r1_busy",  32'(fetch_busy), 32'd1);
        check("r1_addr",  imem_addr, 32'h0040_0100);
        tick();
        check("r1_wait",  32'(imem_req), 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("r1_drop",  32'(if_id_valid), 32'd0);
        check("r1_req",   32'(imem_req), 32'd1);
        check("r1_naddr", imem_addr, 32'h0040_0100);
`ifdef FETCH_PERF_EN
        check("r1_dcnt",  discard_cnt - snap, 32'd1);
`endif

        // Redirect and rvalid in the same cycle
        tick();
        redirect = 1'b1; if_id_flush = 1'b1; redirect_pc = 32'h0040_0100;
        imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        redirect = 1'b0; if_id_flush = 1'b0; imem_rvalid = 1'b0;
        check("r2_valid", 32'(if_id_valid), 32'd0);
        check("r2_req",   32'(imem_req), 32'd1);
        check("r2_addr",  imem_addr, 32'h0040_0100);
        check("r2_busy",  32'(fetch_busy), 32'd0);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0020;
        tick();
        imem_rvalid = 1'b0;
        check("r2_nocarry", 32'(if_id_valid), 32'd1);
        check("r2_instr",   if_id_instr, 32'h0000_0020);
        check("r2_pc4",     if_id_pc_plus4, 32'h0040_0104);

        // Memory not ready for 4 cycles
`ifdef FETCH_PERF_EN
        snap = bubble_cnt;
`endif
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("nr_req%0d", i),   32'(imem_req), 32'd1);
            check($sformatf("nr_addr%0d", i),  imem_addr, 32'h0040_0104);
            check($sformatf("nr_valid%0d", i), 32'(if_id_valid), 32'd0);
        end
`ifdef FETCH_PERF_EN
        check("nr_bcnt", bubble_cnt - snap, 32'd4);
`endif

        // Redirect in S_REQ while not accepted, then PC wrap at 2^32
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        check("w_addr", imem_addr, 32'hFFFF_FFFC);
        check("w_req",  32'(imem_req), 32'd1);
        imem_ready = 1'b1;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0033;
        tick();
        imem_rvalid = 1'b0;
        check("w_instr", if_id_instr, 32'h0000_0033);
        check("w_pc4",   if_id_pc_plus4, 32'h0000_0000);
        check("w_next",  imem_addr, 32'h0000_0000);

        // Reset while waiting; late response ignored
        tick();
        check("rw_busy", 32'(fetch_busy), 32'd1);
        rst = 1'b1;
        tick();
        check("rw_addr",  imem_addr, 32'h0040_0000);
        check("rw_req",   32'(imem_req), 32'd1);
        check("rw_valid", 32'(if_id_valid), 32'd0);
        check("rw_instr", if_id_instr, 32'h0);
        rst = 1'b0; imem_ready = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BAD;
        tick();
        imem_rvalid = 1'b0;
        check("rw_late_valid", 32'(if_id_valid), 32'd0);
        check("rw_late_busy",  32'(fetch_busy), 32'd0);
        imem_ready = 1'b1;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0011;
        tick();
        imem_rvalid = 1'b0;
        check("rw_instr2", if_id_instr, 32'h0000_0011);
        check("rw_pc4",    if_id_pc_plus4, 32'h0040_0004);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF stage of the 5-stage MIPS pipeline; consumes the hazard unit's stall/flush outputs (pc_keep, IF_ID_keep, IF_ID_flush) plus the ID-stage redirect.
- Owns the PC register, the IF/ID pipeline register and a one-entry hold buffer.
- Fetches from a variable-latency instruction memory over a req/ready + rvalid handshake, one outstanding request.
- Presents instruction, PC+4 and valid to ID.

Parameters:
PC_RESET, 32'h0040_0000, PC value loaded on reset
DATA_W, 32, instruction/address width (fixed 32; parameter for package consistency only)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, synchronous, active-high
i_pc_keep  in  1  hold PC (load-use stall)
i_IF_ID_keep  in  1  hold IF/ID contents
i_IF_ID_flush  in  1  squash IF/ID (branch taken / jump)
i_redirect  in  1  ID resolved taken branch or jump this cycle
i_redirect_pc  in  32  redirect target
o_imem_req  out  1  fetch request valid
o_imem_addr  out  32  fetch address (= PC)
i_imem_ready  in  1  memory accepts request this cycle
i_imem_rvalid  in  1  response valid (>=1 cycle after accept)
i_imem_rdata  in  32  instruction word
o_IF_ID_instr  out  32  instruction to ID
o_IF_ID_pc_plus4  out  32  PC+4 of that instruction
o_IF_ID_valid  out  1  IF/ID holds a real instruction
o_fetch_busy  out  1  request outstanding or hold buffer full

Behaviour:
Reset:
- PC=PC_RESET, state=S_REQ, o_IF_ID_instr=0 (nop), o_IF_ID_pc_plus4=0, o_IF_ID_valid=0, discard=0, hold buffer empty.
- Reset overrides every other input.

FSM:
- S_REQ: o_imem_req=1, o_imem_addr=PC. Accept (i_imem_ready=1) -> S_WAIT; else stay.
- S_WAIT: o_imem_req=0; awaiting i_imem_rvalid.
  - rvalid, discard=1: drop data, clear discard -> S_REQ.
  - rvalid, IF/ID loadable (IF_ID_keep=0): load IF/ID -> S_REQ.
  - rvalid, IF_ID_keep=1: capture {rdata, PC+4} into hold buffer -> S_HOLD.
- S_HOLD: no request. When IF_ID_keep=0 and no flush: load IF/ID from buffer -> S_REQ.

PC rules:
- Priority: reset > i_redirect > advance.
- Advance: PC <= PC+4 on the cycle the fetched word enters IF/ID (direct or from buffer), unless i_pc_keep.
- Wraps mod 2^32, no trap.
- PC is never changed while a request is outstanding, except by redirect.

Redirect (same cycle as i_IF_ID_flush in normal use):
- PC <= i_redirect_pc.
- S_WAIT without rvalid this cycle: set discard, stay S_WAIT.
- S_WAIT with rvalid this cycle: drop data -> S_REQ.
- S_HOLD: empty hold buffer -> S_REQ.
- S_REQ: the request is accepted this cycle or not.
  - If accepted: set discard -> S_WAIT. The new request issues after that response returns.
  - If not accepted: next cycle requests the new PC.

IF/ID register, per cycle, priority order:
1. flush -> instr=0, pc_plus4=0, valid=0.
2. keep -> hold all fields.
3. New word available (non-discarded rvalid in S_WAIT, or buffer in S_HOLD) -> load, valid=1.
4. Otherwise -> valid=0, instr=0 (bubble).

Other rules:
- Flush with keep: flush wins.
- Flush without redirect: only IF/ID is squashed; a fetch in flight completes normally.
- Latency: accept at cycle N, rvalid at N+k, instruction visible on o_IF_ID_* at N+k+1. With k=1, back-to-back throughput is one instruction per 2 cycles (no prefetch).
- o_fetch_busy = (state==S_WAIT) | (state==S_HOLD).

Optional Feature:
FETCH_PERF_EN:
- Defined: adds o_bubble_cnt[31:0] (increments each cycle rule 4 applies) and o_discard_cnt[31:0] (increments per dropped response). Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Shared package cpu_pkg: state encoding S_REQ/S_WAIT/S_HOLD, NOP_INSTR=32'h0, PC_RESET default constant.
- One natural sub-module: if_id_reg, the IF/ID register implementing flush > keep > load > bubble priority. It is reused by later pipeline registers.
- PC, FSM and hold buffer stay in fetch_stage.

Test Plan:
- Reset, then memory with ready=1 and rvalid after 1 cycle returning 0x2008_0005 -> first request addr 0x0040_0000; IF/ID instr=0x2008_0005, pc_plus4=0x0040_0004, valid=1; next request addr 0x0040_0004.
- IF_ID_keep=pc_keep=1 for 3 cycles while rvalid arrives with 0x8C09_0000 -> S_HOLD, IF/ID unchanged, no new request; after keep drops IF/ID=0x8C09_0000, PC advances by 4 once.
- Redirect to 0x0040_0100 with flush while in S_WAIT; rvalid 2 cycles later with 0xDEAD_BEEF -> word dropped, IF/ID valid=0, next request addr 0x0040_0100, discard count +1 with FETCH_PERF_EN.
- Redirect and rvalid in the same cycle -> data dropped, request 0x0040_0100 the following cycle, no discard carried.
- i_imem_ready=0 for 4 cycles -> req held high, addr stable, IF/ID valid=0 each cycle, bubble count +4.
- i_rst asserted in S_WAIT -> next cycle PC=PC_RESET, IF/ID cleared, late rvalid ignored; request restarts at 0x0040_0000.
